// File: rtl/noc_sync_pkg.sv
// Shared types and constants for the clocked-to-asynchronous flit injector.
package noc_sync_pkg;

    localparam int FLIT_W_DEF = 9;
    localparam int FLIT_CNT_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_t;

endpackage

// File: rtl/flit_fifo.sv
// DEPTH x FLIT_W register FIFO with occupancy count. No write-to-read bypass:
// a flit becomes visible to pop on the edge after it was pushed.
module flit_fifo #(
    parameter int FLIT_W = 9,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              CLK,
    input  logic              _RESET,
    input  logic              push,
    input  logic [FLIT_W-1:0] push_data,
    input  logic              pop,
    output logic [FLIT_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sync_flit_injector.sv
// Host valid/ready flits -> FIFO -> four-phase RTZ dual-rail channel toward the router P input.
//   state | meaning
//   IDLE  | rails null; wait for synchronised enable high and a buffered flit
//   DRIVE | codeword held on rails; wait for synchronised enable low (acknowledge)
module sync_flit_injector
    import noc_sync_pkg::*;
#(
    parameter int FLIT_W      = FLIT_W_DEF,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    localparam int LVL_W      = $clog2(DEPTH) + 1
) (
    input  logic                  CLK,
    input  logic                  _RESET,
    input  logic [FLIT_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [FLIT_W-1:0]     out_t,
    output logic [FLIT_W-1:0]     out_f,
    input  logic                  out_e,
    output logic [LVL_W-1:0]      fifo_level,
    output logic [FLIT_CNT_W-1:0] flit_count
);

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   e_s;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [FLIT_W-1:0]      head;
    logic                   push;
    logic                   pop;

    assign e_s      = sync_q[SYNC_STAGES-1];
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    assign pop      = (state == IDLE) && e_s && !fifo_empty;

    // out_e is asynchronous to CLK; nothing downstream looks at it before the last stage.
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], out_e};
        end
    end

    flit_fifo #(
        .FLIT_W (FLIT_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        ._RESET    (_RESET),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_level)
    );

    // Rails are only ever loaded from null or cleared to null, so no rail can glitch inside DRIVE.
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            state      <= IDLE;
            out_t      <= '0;
            out_f      <= '0;
            flit_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        out_t <= head;
                        out_f <= ~head;
                        state <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (!e_s) begin
                        out_t      <= '0;
                        out_f      <= '0;
                        flit_count <= flit_count + FLIT_CNT_W'(1);
                        state      <= IDLE;
                    end
                end
                default: begin
                    out_t <= '0;
                    out_f <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sync_flit_injector.sv
// Directed and randomised bench for sync_flit_injector with a four-phase router model and a flit scoreboard.
module tb_sync_flit_injector;

    localparam int FLIT_W      = 9;
    localparam int DEPTH       = 4;
    localparam int SYNC_STAGES = 2;
    localparam int LVL_W       = $clog2(DEPTH) + 1;
    localparam int N_RANDOM    = 100;

    logic              CLK = 1'b0;
    logic              rst_n;
    logic [FLIT_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [FLIT_W-1:0] out_t;
    logic [FLIT_W-1:0] out_f;
    logic              out_e;
    logic [LVL_W-1:0]  fifo_level;
    logic [15:0]       flit_count;

    int errors = 0;
    int checks = 0;
    logic [FLIT_W-1:0] exp_q [$];
    bit router_done;

    always #5 CLK = ~CLK;

    sync_flit_injector #(
        .FLIT_W      (FLIT_W),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .CLK        (CLK),
        ._RESET     (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_t      (out_t),
        .out_f      (out_f),
        .out_e      (out_e),
        .fifo_level (fifo_level),
        .flit_count (flit_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a full codeword (want_code=1) or null rails (want_code=0).
    task automatic wait_rails(input bit want_code, input int limit, input string tag);
        int n = 0;
        logic [FLIT_W-1:0] target;
        target = want_code ? {FLIT_W{1'b1}} : {FLIT_W{1'b0}};
        while (n < limit && (out_t | out_f) !== target) begin
            @(negedge CLK);
            n++;
        end
        check(tag, 32'(n < limit), 32'd1);
    endtask

    task automatic push_flit(input logic [FLIT_W-1:0] d, input bit expect_out);
        @(negedge CLK);
        in_data  = d;
        in_valid = 1'b1;
        if (expect_out) exp_q.push_back(d);
    endtask

    task automatic router(input int n_flits);
        logic [FLIT_W-1:0] got;
        logic [FLIT_W-1:0] inv;
        logic [FLIT_W-1:0] exp;
        out_e = 1'b1;
        for (int i = 0; i < n_flits; i++) begin
            wait_rails(1'b1, 300, "rx_code_timeout");
            repeat ($urandom_range(0, 7)) @(negedge CLK);
            got = out_t;
            inv = ~out_t;
            check("rx_false_rail", 32'(out_f), 32'(inv));
            check("rx_queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                check("rx_data", 32'(got), 32'(exp));
            end
            out_e = 1'b0;
            wait_rails(1'b0, 300, "rx_null_timeout");
            repeat ($urandom_range(0, 7)) @(negedge CLK);
            out_e = 1'b1;
        end
        router_done = 1'b1;
    endtask

    initial begin
        logic [FLIT_W-1:0] exp;
        logic [FLIT_W-1:0] inv;
        int sent;
        int guard;

        rst_n       = 1'b0;
        out_e       = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        router_done = 1'b0;

        // Reset values
        repeat (3) @(negedge CLK);
        check("rst_out_t", 32'(out_t), 32'h0);
        check("rst_out_f", 32'(out_f), 32'h0);
        check("rst_level", 32'(fifo_level), 32'h0);
        check("rst_count", 32'(flit_count), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        rst_n = 1'b1;

        // Idle with enable high and empty FIFO: rails stay null
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            check("idle_rails", 32'({out_t, out_f}), 32'h0);
        end
        check("idle_in_ready", 32'(in_ready), 32'h1);
        check("idle_level", 32'(fifo_level), 32'h0);

        // Single flit latency and acknowledge
        push_flit(9'h1A5, 1'b1);
        @(negedge CLK);
        in_valid = 1'b0;
        check("lat_level_after_push", 32'(fifo_level), 32'h1);
        check("lat_rails_null_edge_k", 32'({out_t, out_f}), 32'h0);
        @(negedge CLK);
        exp = exp_q.pop_front();
        inv = ~exp;
        check("lat_out_t", 32'(out_t), 32'(exp));
        check("lat_out_f", 32'(out_f), 32'(inv));
        check("lat_level_after_pop", 32'(fifo_level), 32'h0);
        out_e = 1'b0;
        repeat (SYNC_STAGES) @(negedge CLK);
        check("ack_still_driven", 32'(out_t), 32'h1A5);
        @(negedge CLK);
        check("ack_rails_null", 32'({out_t, out_f}), 32'h0);
        check("ack_count_1", 32'(flit_count), 32'h1);

        // Fill FIFO with enable low
        push_flit(9'h001, 1'b1);
        push_flit(9'h0FF, 1'b1);
        push_flit(9'h100, 1'b1);
        push_flit(9'h1FF, 1'b1);
        @(negedge CLK);
        check("full_level", 32'(fifo_level), 32'h4);
        check("full_in_ready", 32'(in_ready), 32'h0);
        check("full_rails_null", 32'({out_t, out_f}), 32'h0);
        in_data = 9'h0AA;
        repeat (2) @(negedge CLK);
        check("full_push_ignored_level", 32'(fifo_level), 32'h4);
        check("full_push_ignored_ready", 32'(in_ready), 32'h0);
        in_valid = 1'b0;

        // Drain the 4 plus 100 random flits through the router model
        fork
            router(4 + N_RANDOM);
            begin
                sent  = 0;
                guard = 0;
                while (sent < N_RANDOM && guard < 20000) begin
                    @(negedge CLK);
                    guard++;
                    if (in_ready && $urandom_range(0, 3) != 0) begin
                        in_data  = FLIT_W'($urandom);
                        in_valid = 1'b1;
                        exp_q.push_back(in_data);
                        sent++;
                    end else begin
                        in_valid = 1'b0;
                    end
                end
                @(negedge CLK);
                in_valid = 1'b0;
                check("host_sent_all", 32'(sent), 32'(N_RANDOM));
            end
            begin
                while (!router_done) begin
                    @(negedge CLK);
                    check("rail_exclusive", 32'(out_t & out_f), 32'h0);
                end
            end
        join
        check("stream_count", 32'(flit_count), 32'(5 + N_RANDOM));
        check("stream_queue_drained", 32'(exp_q.size()), 32'h0);

        // Reset while a codeword is on the rails, with one flit still buffered
        push_flit(9'h155, 1'b1);
        push_flit(9'h0F0, 1'b0);
        @(negedge CLK);
        in_valid = 1'b0;
        wait_rails(1'b1, 50, "mid_code_timeout");
        exp = exp_q.pop_front();
        check("mid_out_t", 32'(out_t), 32'(exp));
        check("mid_level", 32'(fifo_level), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_rails", 32'({out_t, out_f}), 32'h0);
        check("async_rst_level", 32'(fifo_level), 32'h0);
        check("async_rst_count", 32'(flit_count), 32'h0);
        repeat (2) @(negedge CLK);
        rst_n = 1'b1;
        out_e = 1'b1;
        repeat (6) @(negedge CLK);
        check("post_rst_rails", 32'({out_t, out_f}), 32'h0);
        check("post_rst_level", 32'(fifo_level), 32'h0);

        // Counter wrap
        @(negedge CLK);
        force dut.flit_count = 16'hFFFF;
        @(negedge CLK);
        release dut.flit_count;
        check("wrap_preload", 32'(flit_count), 32'hFFFF);
        push_flit(9'h0C3, 1'b1);
        @(negedge CLK);
        in_valid = 1'b0;
        wait_rails(1'b1, 50, "wrap_code_timeout");
        exp = exp_q.pop_front();
        check("wrap_out_t", 32'(out_t), 32'(exp));
        out_e = 1'b0;
        wait_rails(1'b0, 50, "wrap_null_timeout");
        check("wrap_count", 32'(flit_count), 32'h0);
        out_e = 1'b1;
        repeat (2) @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
